// File: rtl/tmds_channel_encoder.sv
// DVI 1.0 TMDS encoder for one channel: 8b pixel / 2b control in, 10b symbol out.
// Two register stages: transition-minimized q_m, then DC-balance selection with running disparity.
module tmds_channel_encoder #(
  parameter bit INVERT_OUTPUT = 1'b0
) (
  input  logic              clk_pixel,
  input  logic              reset,
  input  logic [7:0]        d,
  input  logic [1:0]        c,
  input  logic              de,
  output logic [9:0]        q_out,
  output logic signed [4:0] disparity
);

  localparam logic [9:0] CTRL_00   = 10'b1101010100;
  localparam logic [9:0] CTRL_01   = 10'b0010101011;
  localparam logic [9:0] CTRL_10   = 10'b0101010100;
  localparam logic [9:0] CTRL_11   = 10'b1010101011;
  localparam logic [9:0] RESET_SYM = INVERT_OUTPUT ? ~CTRL_00 : CTRL_00;

  // Stage 1 combinational: transition minimization of d
  logic [3:0] d_ones;
  logic       use_xnor;
  logic       prev;
  logic [8:0] qm_next;

  always_comb begin
    d_ones = '0;
    for (int i = 0; i < 8; i++) d_ones = d_ones + {3'b000, d[i]};
    use_xnor = (d_ones > 4'd4) || ((d_ones == 4'd4) && !d[0]);
    prev       = d[0];
    qm_next    = '0;
    qm_next[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      prev       = use_xnor ? ~(prev ^ d[i]) : (prev ^ d[i]);
      qm_next[i] = prev;
    end
    qm_next[8] = ~use_xnor;
  end

  logic       de_r;
  logic [1:0] c_r;
  logic [8:0] qm_r;

  // q_m is forced to zero on control cycles so an undriven d never reaches stage 2
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      de_r <= 1'b0;
      c_r  <= 2'b00;
      qm_r <= '0;
    end else begin
      de_r <= de;
      c_r  <= c;
      qm_r <= de ? qm_next : 9'd0;
    end
  end

  // Stage 2 combinational: symbol choice and disparity update
  logic signed [4:0] cnt;
  logic [3:0]        qm_ones;
  logic signed [5:0] diff;
  logic signed [5:0] cnt_ext;
  logic signed [5:0] cnt_next;
  logic [9:0]        sym;

  always_comb begin
    qm_ones = '0;
    for (int i = 0; i < 8; i++) qm_ones = qm_ones + {3'b000, qm_r[i]};
    diff     = $signed({1'b0, qm_ones, 1'b0}) - 6'sd8;  // n1 - n0
    cnt_ext  = $signed({cnt[4], cnt});
    sym      = CTRL_00;
    cnt_next = '0;
    if (!de_r) begin
      case (c_r)
        2'b00:   sym = CTRL_00;
        2'b01:   sym = CTRL_01;
        2'b10:   sym = CTRL_10;
        default: sym = CTRL_11;
      endcase
    end else if ((cnt == 5'sd0) || (diff == 6'sd0)) begin
      sym      = {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]};
      cnt_next = qm_r[8] ? (cnt_ext + diff) : (cnt_ext - diff);
    end else if ((!cnt[4] && (diff > 6'sd0)) || (cnt[4] && (diff < 6'sd0))) begin
      sym      = {1'b1, qm_r[8], ~qm_r[7:0]};
      cnt_next = cnt_ext + (qm_r[8] ? 6'sd2 : 6'sd0) - diff;
    end else begin
      sym      = {1'b0, qm_r[8], qm_r[7:0]};
      cnt_next = cnt_ext + diff - (qm_r[8] ? 6'sd0 : 6'sd2);
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      q_out <= RESET_SYM;
    end else begin
      cnt   <= $signed(cnt_next[4:0]);
      q_out <= INVERT_OUTPUT ? ~sym : sym;
    end
  end

  assign disparity = cnt;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder: directed DVI vectors plus random pixels against a reference model,
// with a polarity-inverted instance sharing the same inputs.
module tb_tmds_channel_encoder;

  localparam int W = 24;  // {de, d[7:0], sym[9:0], disp[4:0]}

  logic              clk_pixel = 1'b0;
  logic              reset;
  logic [7:0]        d;
  logic [1:0]        c;
  logic              de;
  logic [9:0]        q_out, q_out_inv;
  logic signed [4:0] disparity, disparity_inv;

  logic [W-1:0] exp_q[$];
  int           model_cnt;
  int           check_count = 0;
  int           pass_count  = 0;

  tmds_channel_encoder #(.INVERT_OUTPUT(1'b0)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .d(d), .c(c), .de(de),
    .q_out(q_out), .disparity(disparity)
  );

  tmds_channel_encoder #(.INVERT_OUTPUT(1'b1)) dut_inv (
    .clk_pixel(clk_pixel), .reset(reset), .d(d), .c(c), .de(de),
    .q_out(q_out_inv), .disparity(disparity_inv)
  );

  // Clock / reset
  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    check_count++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else pass_count++;
  endtask

  // Reference model: DVI 1.0 encoding, one symbol per call, running disparity kept as an int
  task automatic model_step(input logic de_i, input logic [7:0] d_i, input logic [1:0] c_i,
                            output logic [9:0] sym, output logic [4:0] disp);
    int         n1d, n1, n0;
    bit         xn;
    logic [8:0] qm;
    if (!de_i) begin
      case (c_i)
        2'b00:   sym = 10'h354;
        2'b01:   sym = 10'h0AB;
        2'b10:   sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
      model_cnt = 0;
    end else begin
      n1d = $countones(d_i);
      xn  = (n1d > 4) || (n1d == 4 && d_i[0] == 1'b0);
      qm[0] = d_i[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d_i[i]) : (qm[i-1] ^ d_i[i]);
      qm[8] = !xn;
      n1 = $countones(qm[7:0]);
      n0 = 8 - n1;
      if (model_cnt == 0 || n1 == n0) begin
        sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        model_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
      end else if ((model_cnt > 0 && n1 > n0) || (model_cnt < 0 && n0 > n1)) begin
        sym = {1'b1, qm[8], ~qm[7:0]};
        model_cnt += 2 * int'(qm[8]) + (n0 - n1);
      end else begin
        sym = {1'b0, qm[8], qm[7:0]};
        model_cnt += (n1 - n0) - 2 * int'(!qm[8]);
      end
    end
    disp = 5'(model_cnt);
  endtask

  function automatic logic [7:0] decode(input logic [9:0] q);
    logic [7:0] b, r;
    b    = q[9] ? ~q[7:0] : q[7:0];
    r[0] = b[0];
    for (int i = 1; i < 8; i++) r[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    return r;
  endfunction

  // Driver: one input per cycle; the symbol for an input appears one edge after it is sampled
  task automatic drive(input logic de_i, input logic [7:0] d_i, input logic [1:0] c_i);
    logic [W-1:0] e;
    logic [9:0]   s;
    logic [4:0]   dp;
    @(negedge clk_pixel);
    de = de_i; d = d_i; c = c_i;
    @(posedge clk_pixel);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("q_out", {6'd0, q_out}, {6'd0, e[14:5]});
      check("disparity", {11'd0, disparity}, {11'd0, e[4:0]});
      check("q_out_inv", {6'd0, q_out_inv}, {6'd0, ~e[14:5]});
      check("disparity_inv", {11'd0, disparity_inv}, {11'd0, e[4:0]});
      if (e[23]) check("decode", {8'd0, decode(q_out)}, {8'd0, e[22:15]});
    end
    model_step(de_i, d_i, c_i, s, dp);
    exp_q.push_back({de_i, d_i, s, dp});
  endtask

  task automatic release_reset();
    @(negedge clk_pixel);
    reset = 1'b0;
    exp_q.delete();
    model_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; de = 1'b0; d = 8'h00; c = 2'b00;
    model_cnt = 0;
    repeat (3) @(posedge clk_pixel);
    #1;
    check("rst_q_out", {6'd0, q_out}, 16'h0354);
    check("rst_disp", {11'd0, disparity}, 16'h0000);
    check("rst_q_out_inv", {6'd0, q_out_inv}, 16'h00AB);
    release_reset();

    // Three zero pixels from cnt=0
    drive(1'b1, 8'h00, 2'b00);
    drive(1'b1, 8'h00, 2'b00);
    check("z0_q", {6'd0, q_out}, 16'h0100);
    check("z0_d", {11'd0, disparity}, {11'd0, 5'(-8)});
    check("z0_qi", {6'd0, q_out_inv}, 16'h02FF);
    drive(1'b1, 8'h00, 2'b00);
    check("z1_q", {6'd0, q_out}, 16'h03FF);
    check("z1_d", {11'd0, disparity}, {11'd0, 5'(2)});
    check("z1_qi", {6'd0, q_out_inv}, 16'h0000);
    drive(1'b0, 8'hxx, 2'b00);
    check("z2_q", {6'd0, q_out}, 16'h0100);
    check("z2_d", {11'd0, disparity}, {11'd0, 5'(-6)});
    check("z2_qi", {6'd0, q_out_inv}, 16'h02FF);

    // 0xFF from cnt=0 (previous symbol was control), then control 00
    drive(1'b1, 8'hFF, 2'b00);
    drive(1'b0, 8'hxx, 2'b00);
    check("ff_q", {6'd0, q_out}, 16'h0200);
    check("ff_d", {11'd0, disparity}, {11'd0, 5'(-8)});
    drive(1'b0, 8'hxx, 2'b01);
    check("c00_q", {6'd0, q_out}, 16'h0354);
    check("c00_d", {11'd0, disparity}, 16'h0000);

    // Control stepping
    drive(1'b0, 8'hxx, 2'b10);
    check("c01_q", {6'd0, q_out}, 16'h00AB);
    drive(1'b0, 8'hxx, 2'b11);
    check("c10_q", {6'd0, q_out}, 16'h0154);
    drive(1'b0, 8'hxx, 2'b00);
    check("c11_q", {6'd0, q_out}, 16'h02AB);
    check("c11_d", {11'd0, disparity}, 16'h0000);

    // Long random pixel run
    for (int i = 0; i < 10000; i++) drive(1'b1, 8'($urandom_range(0, 255)), 2'b00);

    // Random de toggling with undriven pixels on control cycles
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) drive(1'b1, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      else drive(1'b0, 8'hxx, 2'($urandom_range(0, 3)));
    end

    // Asynchronous reset between edges
    @(posedge clk_pixel);
    #3;
    reset = 1'b1; de = 1'b0; d = 8'h00; c = 2'b00;
    #1;
    check("async_q", {6'd0, q_out}, 16'h0354);
    check("async_d", {11'd0, disparity}, 16'h0000);
    check("async_qi", {6'd0, q_out_inv}, 16'h00AB);
    release_reset();

    for (int i = 0; i < 50; i++) drive(1'b1, 8'($urandom_range(0, 255)), 2'b00);
    drive(1'b0, 8'hxx, 2'b00);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
